// File: rtl/user_ram_arbiter.sv
// Two-requester valid/ready arbiter and sequencer in front of a single-port synchronous user_ram.
// Define USER_RAM_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module user_ram_arbiter #(
  parameter int unsigned ADDR_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                req0_valid_i,
  input  logic                req0_we_i,
  input  logic [ADDR_BIT-1:0] req0_addr_i,
  input  logic [31:0]         req0_wdata_i,
  output logic                req0_ready_o,
  output logic [31:0]         req0_rdata_o,
  output logic                req0_rvalid_o,

  input  logic                req1_valid_i,
  input  logic                req1_we_i,
  input  logic [ADDR_BIT-1:0] req1_addr_i,
  input  logic [31:0]         req1_wdata_i,
  output logic                req1_ready_o,
  output logic [31:0]         req1_rdata_o,
  output logic                req1_rvalid_o,

  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_di_o,
  input  logic [31:0]         ram_do_i
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_DATA = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        rd_owner_q, rd_owner_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic        gnt0, gnt1;

`ifndef USER_RAM_ARB_FIXED_PRIO_EN
  logic        last_gnt_q, last_gnt_d;
`endif

  // Grants are gated by rst_i so every command output drops as soon as reset asserts.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_i && (state_q == ST_IDLE)) begin
`ifdef USER_RAM_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid_i;
      gnt1 = req1_valid_i & ~req0_valid_i;
`else
      if (req0_valid_i && req1_valid_i) begin
        gnt0 = last_gnt_q;
        gnt1 = ~last_gnt_q;
      end else begin
        gnt0 = req0_valid_i;
        gnt1 = req1_valid_i;
      end
`endif
    end
  end

  always_comb begin
    ram_wr_en_o = 1'b0;
    ram_rd_en_o = 1'b0;
    ram_addr_o  = '0;
    ram_di_o    = '0;
    if (gnt0) begin
      ram_wr_en_o = req0_we_i;
      ram_rd_en_o = ~req0_we_i;
      ram_addr_o  = req0_addr_i;
      ram_di_o    = req0_wdata_i;
    end else if (gnt1) begin
      ram_wr_en_o = req1_we_i;
      ram_rd_en_o = ~req1_we_i;
      ram_addr_o  = req1_addr_i;
      ram_di_o    = req1_wdata_i;
    end
  end

  assign req0_ready_o  = gnt0;
  assign req1_ready_o  = gnt1;
  assign req0_rdata_o  = rdata0_q;
  assign req1_rdata_o  = rdata1_q;
  assign req0_rvalid_o = rvalid0_q;
  assign req1_rvalid_o = rvalid1_q;

  always_comb begin
    state_d    = state_q;
    rd_owner_d = rd_owner_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
`ifndef USER_RAM_ARB_FIXED_PRIO_EN
    last_gnt_d = last_gnt_q;
    if (gnt0 || gnt1) begin
      last_gnt_d = gnt1;
    end
`endif
    unique case (state_q)
      ST_IDLE: begin
        if ((gnt0 && !req0_we_i) || (gnt1 && !req1_we_i)) begin
          state_d    = ST_RD_DATA;
          rd_owner_d = gnt1;
        end
      end
      ST_RD_DATA: begin
        // RAM output is only trusted here, the cycle after rd_en.
        if (rd_owner_q) begin
          rdata1_d  = ram_do_i;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_do_i;
          rvalid0_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      rd_owner_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

`ifndef USER_RAM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

endmodule
